// File: rtl/mmio_interconnect.sv
// Purpose: routes one master MMIO transaction at a time to the slave owning its 4-bit address region.
// Latency: hit = 2 cycles minimum (req edge -> ack edge -> m_ready); miss = 1 cycle; timeout = TIMEOUT+1.
// Backpressure: master holds m_req until the m_ready pulse; new requests are sampled only when idle.
module mmio_interconnect #(
  parameter int                    NUM_SLAVES = 4,
  parameter int                    REGION_LSB = 8,
  parameter logic [4*NUM_SLAVES-1:0] REGIONS  = {4'd9, 4'd8, 4'd1, 4'd0},
  parameter int                    TIMEOUT    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       m_req,
  input  logic                       m_we,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wd,
  output logic [31:0]                m_rd,
  output logic                       m_ready,
  output logic                       m_err,
  output logic                       busy,
  output logic [NUM_SLAVES-1:0]      s_req,
  output logic                       s_we,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wd,
  input  logic [NUM_SLAVES*32-1:0]   s_rd,
  input  logic [NUM_SLAVES-1:0]      s_ack,
  output logic [7:0]                 err_count
);

  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [TW-1:0]           timer;
  logic [3:0]              field;
  logic                    dec_hit;
  logic [NUM_SLAVES-1:0]   dec_oh;
  logic                    sel_ack;
  logic [31:0]             rd_sel;
  logic                    start;
  logic                    ack_done;
  logic                    to_done;
  logic                    timer_inc;
  logic                    err_evt;

  assign field   = m_addr[REGION_LSB +: 4];
  assign sel_ack = |(s_ack & s_req);
  assign m_ready = (state == RESP);
  assign busy    = (state != IDLE);
  assign err_evt = (start && !dec_hit) || to_done;

  // Region decode; scanning from the top down lets the lowest matching index win.
  always_comb begin
    dec_hit = 1'b0;
    dec_oh  = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (REGIONS[4*i +: 4] == field) begin
        dec_hit = 1'b1;
        dec_oh  = NUM_SLAVES'(1) << i;
      end
    end
  end

  // Read-data mux driven by the one-hot request of the selected slave.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rd_sel = rd_sel | (s_rd[32*i +: 32] & {32{s_req[i]}});
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and per-cycle event strobes for the datapath.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    ack_done  = 1'b0;
    to_done   = 1'b0;
    timer_inc = 1'b0;
    case (state)
      IDLE: begin
        if (m_req) begin
          start     = 1'b1;
          state_nxt = dec_hit ? WAIT : RESP;
        end
      end
      WAIT: begin
        // An ack in the last allowed cycle beats the timeout.
        if (sel_ack) begin
          ack_done  = 1'b1;
          state_nxt = RESP;
        end else if (timer == TMAX) begin
          to_done   = 1'b1;
          state_nxt = RESP;
        end else begin
          timer_inc = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the request, track the wait timer, capture the response and count errors.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wd      <= '0;
      s_req     <= '0;
      timer     <= '0;
      m_rd      <= '0;
      m_err     <= 1'b0;
      err_count <= '0;
    end else begin
      if (start) begin
        s_we   <= m_we;
        s_addr <= m_addr;
        s_wd   <= m_wd;
        s_req  <= dec_oh;
        timer  <= '0;
      end
      if (timer_inc) timer <= timer + 1'b1;
      if (ack_done) begin
        m_rd  <= rd_sel;
        m_err <= 1'b0;
        s_req <= '0;
      end
      if (err_evt) begin
        m_rd  <= '0;
        m_err <= 1'b1;
        s_req <= '0;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Purpose: randomized and directed bench for mmio_interconnect against a region/latency model.
// Latency: model predicts m_ready cycle count from region decode and slave ack delay.
// Backpressure: bench holds m_req until m_ready, then drops it for the idle cycle.
module tb_mmio_interconnect;
  localparam int NS = 4;
  localparam int TO = 16;

  logic              clock, reset;
  logic              m_req, m_we;
  logic [31:0]       m_addr, m_wd, m_rd;
  logic              m_ready, m_err, busy;
  logic [NS-1:0]     s_req;
  logic              s_we;
  logic [31:0]       s_addr, s_wd;
  logic [NS*32-1:0]  s_rd;
  logic [NS-1:0]     s_ack;
  logic [7:0]        err_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_errs = 0;
  int region_of [NS] = '{0, 1, 8, 9};

  mmio_interconnect #(.NUM_SLAVES(NS), .REGION_LSB(8), .REGIONS({4'd9, 4'd8, 4'd1, 4'd0}), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd),
    .m_rd(m_rd), .m_ready(m_ready), .m_err(m_err), .busy(busy), .s_req(s_req), .s_we(s_we),
    .s_addr(s_addr), .s_wd(s_wd), .s_rd(s_rd), .s_ack(s_ack), .err_count(err_count));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model: slave owning the address region, lowest index first; -1 when unmapped.
  function automatic int model_decode(logic [31:0] a);
    int f;
    f = int'((a >> 8) & 32'hF);
    for (int i = 0; i < NS; i++) if (region_of[i] == f) return i;
    return -1;
  endfunction

  function automatic int model_lat(int idx, int d);
    if (idx < 0) return 1;
    if (d >= 0 && d < TO) return d + 2;
    return TO + 1;
  endfunction

  function automatic logic model_err(int idx, int d);
    return (idx < 0) || !(d >= 0 && d < TO);
  endfunction

  // Drives one transaction; ack_slave acks on WAIT cycle ack_delay (-1 = never); stray is ORed in always.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input int ack_slave, input int ack_delay, input logic [31:0] rdata,
                         input logic [NS-1:0] stray, output int lat, output logic [31:0] rd,
                         output logic err, output logic [NS-1:0] sreq_seen,
                         output logic [31:0] saddr_seen, output logic [31:0] swd_seen,
                         output logic swe_seen);
    int c;
    c = 0; lat = -1; rd = 'x; err = 1'bx;
    sreq_seen = 'x; saddr_seen = 'x; swd_seen = 'x; swe_seen = 1'bx;
    for (int i = 0; i < NS; i++) s_rd[32*i +: 32] = $urandom();
    if (ack_slave >= 0) s_rd[32*ack_slave +: 32] = rdata;
    m_req = 1'b1; m_we = we; m_addr = addr; m_wd = wd; s_ack = stray;
    forever begin
      tick();
      c++;
      if (c == 1) begin
        sreq_seen = s_req; saddr_seen = s_addr; swd_seen = s_wd; swe_seen = s_we;
      end
      if (m_ready) begin
        lat = c; rd = m_rd; err = m_err;
        break;
      end
      if (c >= 64) break;
      s_ack = stray;
      if (ack_slave >= 0 && ack_delay >= 0 && (c - 1) == ack_delay)
        s_ack = s_ack | (NS'(1) << ack_slave);
    end
    m_req = 1'b0; s_ack = '0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; s_rd = '0; s_ack = '0;
    repeat (3) tick();
    n_checks++; if (m_ready !== 1'b0 || busy !== 1'b0 || m_err !== 1'b0) $display("FAIL reset_ctl: ready=%b busy=%b err=%b want 0", m_ready, busy, m_err); else n_pass++;
    n_checks++; if (m_rd !== 32'h0 || s_req !== '0 || s_we !== 1'b0) $display("FAIL reset_dat: rd=%h sreq=%b swe=%b want 0", m_rd, s_req, s_we); else n_pass++;
    n_checks++; if (s_addr !== 32'h0 || s_wd !== 32'h0 || err_count !== 8'h0) $display("FAIL reset_bus: addr=%h wd=%h cnt=%h want 0", s_addr, s_wd, err_count); else n_pass++;
    reset = 1'b1;
    tick();
    exp_errs = 0;
  endtask

  task automatic test_read_hit();
    int lat; logic [31:0] rd, sa, sw; logic err, swe; logic [NS-1:0] sr;
    run_txn(1'b0, 32'h0000_0804, 32'h0, 2, 1, 32'h0000_0078, '0, lat, rd, err, sr, sa, sw, swe);
    n_checks++; if (lat !== 3) $display("FAIL read_lat: got %0d want 3", lat); else n_pass++;
    n_checks++; if (sr !== 4'b0100) $display("FAIL read_sreq: got %b want 0100", sr); else n_pass++;
    n_checks++; if (rd !== 32'h78 || err !== 1'b0) $display("FAIL read_data: rd=%h err=%b want 78/0", rd, err); else n_pass++;
    n_checks++; if (sa !== 32'h804 || swe !== 1'b0) $display("FAIL read_latch: addr=%h we=%b want 804/0", sa, swe); else n_pass++;
    n_checks++; if (m_ready !== 1'b0 || busy !== 1'b0) $display("FAIL read_pulse: ready=%b busy=%b want 0/0", m_ready, busy); else n_pass++;
    n_checks++; if (m_rd !== 32'h78 || m_err !== 1'b0) $display("FAIL read_hold: rd=%h err=%b want 78/0", m_rd, m_err); else n_pass++;
  endtask

  task automatic test_write_hit();
    int lat; logic [31:0] rd, sa, sw; logic err, swe; logic [NS-1:0] sr;
    run_txn(1'b1, 32'h0000_0900, 32'hA5, 3, 0, 32'h1234_5678, '0, lat, rd, err, sr, sa, sw, swe);
    n_checks++; if (lat !== 2) $display("FAIL write_lat: got %0d want 2", lat); else n_pass++;
    n_checks++; if (sr !== 4'b1000 || sw !== 32'hA5 || swe !== 1'b1) $display("FAIL write_latch: sreq=%b wd=%h we=%b want 1000/a5/1", sr, sw, swe); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL write_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_unmapped();
    int lat; logic [31:0] rd, sa, sw; logic err, swe; logic [NS-1:0] sr;
    run_txn(1'b0, 32'h0000_0F00, 32'h0, -1, -1, 32'h0, '0, lat, rd, err, sr, sa, sw, swe);
    exp_errs++;
    n_checks++; if (lat !== 1) $display("FAIL unmapped_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (sr !== '0 || err !== 1'b1 || rd !== 32'h0) $display("FAIL unmapped_resp: sreq=%b err=%b rd=%h want 0/1/0", sr, err, rd); else n_pass++;
    n_checks++; if (err_count !== 8'(exp_errs)) $display("FAIL unmapped_cnt: got %0d want %0d", err_count, exp_errs); else n_pass++;
  endtask

  task automatic test_timeout();
    int lat; logic [31:0] rd, sa, sw; logic err, swe; logic [NS-1:0] sr;
    int delays [3] = '{-1, TO - 1, TO};
    for (int k = 0; k < 3; k++) begin
      run_txn(1'b0, 32'h0000_0010, 32'h0, 0, delays[k], 32'hCAFE_0000 + 32'(k), '0, lat, rd, err, sr, sa, sw, swe);
      if (model_err(0, delays[k])) exp_errs++;
      n_checks++; if (lat !== model_lat(0, delays[k])) $display("FAIL timeout_lat[%0d]: got %0d want %0d", k, lat, model_lat(0, delays[k])); else n_pass++;
      n_checks++; if (err !== model_err(0, delays[k])) $display("FAIL timeout_err[%0d]: got %b want %b", k, err, model_err(0, delays[k])); else n_pass++;
    end
    n_checks++; if (err_count !== 8'(exp_errs)) $display("FAIL timeout_cnt: got %0d want %0d", err_count, exp_errs); else n_pass++;
  endtask

  task automatic test_stray_ack();
    int lat; logic [31:0] rd, sa, sw; logic err, swe; logic [NS-1:0] sr;
    run_txn(1'b0, 32'h0000_0020, 32'h0, 0, 3, 32'h0BAD_F00D, 4'b1000, lat, rd, err, sr, sa, sw, swe);
    n_checks++; if (lat !== 5 || rd !== 32'h0BAD_F00D || err !== 1'b0) $display("FAIL stray_hit: lat=%0d rd=%h err=%b want 5/0badf00d/0", lat, rd, err); else n_pass++;
    run_txn(1'b0, 32'h0000_0030, 32'h0, 0, -1, 32'h0, 4'b1110, lat, rd, err, sr, sa, sw, swe);
    exp_errs++;
    n_checks++; if (lat !== TO + 1 || err !== 1'b1 || rd !== 32'h0) $display("FAIL stray_only: lat=%0d err=%b rd=%h want %0d/1/0", lat, err, rd, TO + 1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0F40;
    tick();
    n_checks++; if (m_ready !== 1'b1) $display("FAIL b2b_first: ready=%b want 1", m_ready); else n_pass++;
    tick();
    n_checks++; if (m_ready !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_idle: ready=%b busy=%b want 0/0", m_ready, busy); else n_pass++;
    tick();
    n_checks++; if (m_ready !== 1'b1) $display("FAIL b2b_dup: ready=%b want 1", m_ready); else n_pass++;
    m_req = 1'b0;
    repeat (2) tick();
    exp_errs += 2;
    n_checks++; if (m_ready !== 1'b0 || err_count !== 8'(exp_errs)) $display("FAIL b2b_end: ready=%b cnt=%0d want 0/%0d", m_ready, err_count, exp_errs); else n_pass++;
  endtask

  task automatic test_random();
    int lat, idx, d; logic [31:0] rd, sa, sw, addr, wd, data; logic err, swe, we; logic [NS-1:0] sr;
    int fields [5];
    for (int n = 0; n < 40; n++) begin
      fields = '{0, 1, 8, 9, int'($urandom_range(0, 15))};
      addr = $urandom();
      addr[11:8] = 4'(fields[$urandom_range(0, 4)]);
      wd = $urandom(); data = $urandom(); we = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO + 3));
      idx = model_decode(addr);
      run_txn(we, addr, wd, idx, d, data, '0, lat, rd, err, sr, sa, sw, swe);
      if (model_err(idx, d)) exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
      n_checks++; if (lat !== model_lat(idx, d)) $display("FAIL rand_lat[%0d]: got %0d want %0d", n, lat, model_lat(idx, d)); else n_pass++;
      n_checks++; if (err !== model_err(idx, d) || rd !== (model_err(idx, d) ? 32'h0 : data)) $display("FAIL rand_resp[%0d]: err=%b rd=%h want %b/%h", n, err, rd, model_err(idx, d), model_err(idx, d) ? 32'h0 : data); else n_pass++;
      n_checks++; if (sr !== ((idx < 0) ? NS'(0) : NS'(1) << idx)) $display("FAIL rand_sreq[%0d]: got %b idx %0d", n, sr, idx); else n_pass++;
      n_checks++; if (sa !== addr || sw !== wd || swe !== we) $display("FAIL rand_latch[%0d]: addr=%h wd=%h we=%b want %h/%h/%b", n, sa, sw, swe, addr, wd, we); else n_pass++;
      n_checks++; if (err_count !== 8'(exp_errs)) $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, err_count, exp_errs); else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0104; m_wd = 32'h5555_AAAA; s_ack = 4'b1000;
    repeat (2) tick();
    n_checks++; if (busy !== 1'b1 || s_req !== 4'b0010) $display("FAIL abort_pre: busy=%b sreq=%b want 1/0010", busy, s_req); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || m_ready !== 1'b0 || s_req !== '0 || s_we !== 1'b0) $display("FAIL abort_ctl: busy=%b ready=%b sreq=%b we=%b want 0", busy, m_ready, s_req, s_we); else n_pass++;
    n_checks++; if (s_addr !== 32'h0 || s_wd !== 32'h0 || m_rd !== 32'h0 || m_err !== 1'b0 || err_count !== 8'h0) $display("FAIL abort_dat: addr=%h wd=%h rd=%h err=%b cnt=%0d want 0", s_addr, s_wd, m_rd, m_err, err_count); else n_pass++;
    m_req = 1'b0; s_ack = '0;
    tick();
    reset = 1'b1;
    exp_errs = 0;
    repeat (2) tick();
    n_checks++; if (busy !== 1'b0 || m_ready !== 1'b0) $display("FAIL abort_post: busy=%b ready=%b want 0/0", busy, m_ready); else n_pass++;
  endtask

  task automatic test_saturation();
    int lat; logic [31:0] rd, sa, sw; logic err, swe; logic [NS-1:0] sr;
    for (int n = 0; n < 260; n++) begin
      run_txn(1'b0, 32'h0000_0E00, 32'h0, -1, -1, 32'h0, '0, lat, rd, err, sr, sa, sw, swe);
      exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
      n_checks++; if (err_count !== 8'(exp_errs)) $display("FAIL sat_cnt[%0d]: got %0d want %0d", n, err_count, exp_errs); else n_pass++;
    end
    n_checks++; if (err_count !== 8'hFF) $display("FAIL sat_final: got %h want ff", err_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_hit();
    test_unmapped();
    test_timeout();
    test_stray_ack();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
